// File: rtl/mem_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_sweep_ctrl : read-modify-write sweep over NWORDS words for NPASS passes |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_sweep_ctrl #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned BASE   = 0,
  parameter int unsigned STRIDE = 4,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned NPASS  = 50,
  parameter int unsigned CW     = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] addr,
  output logic          wr_en,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_cnt
);

  localparam int unsigned   IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW-1:0] STEP      = AW'(STRIDE);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(NPASS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    mode_q;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last_word;

  function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] d);
    case (m)
      2'd0:    xform = d;
      2'd1:    xform = {d[DW-2:0], d[DW-1]};
      2'd2:    xform = ~d;
      default: xform = d + DW'(1);
    endcase
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_word = (idx == LAST_IDX);
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept   = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (last_word && (pass_cnt == LAST_PASS)) state_nx = DONE;
        else                                     state_nx = READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address, index and pass count only move on the WRITE edge so the memory sees a stable word for both cycles.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr     <= BASE_ADDR;
      data_out <= '0;
      pass_cnt <= '0;
      mode_q   <= 2'd0;
      idx      <= '0;
    end else if (accept) begin
      mode_q   <= mode;
      addr     <= BASE_ADDR;
      pass_cnt <= '0;
      idx      <= '0;
    end else if (state == READ) begin
      data_out <= xform(mode_q, data_in);
    end else if (state == WRITE) begin
      if (!last_word) begin
        addr <= addr + STEP;
        idx  <= idx + IW'(1);
      end else begin
        addr     <= BASE_ADDR;
        idx      <= '0;
        pass_cnt <= pass_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_sweep_ctrl : three sweep controllers against a word-level model       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_sweep_ctrl;

  localparam int BASE_A   [3] = '{0, 'h100, 'h40};
  localparam int STRIDE_A [3] = '{4, 8, 4};
  localparam int NW_A     [3] = '{4, 4, 1};
  localparam int NP_A     [3] = '{2, 3, 3};

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_v [3];
  logic [1:0]  mode_v  [3];
  logic [31:0] din_v   [3];
  logic [15:0] addr_v  [3];
  logic        wr_v    [3];
  logic [31:0] dout_v  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [3:0]  pc_v    [3];
  logic [31:0] mem     [3][4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_sweep_ctrl #(.DW(32), .AW(16), .BASE(0), .STRIDE(4), .NWORDS(4), .NPASS(2), .CW(4)) u0 (
    .clk(clk), .nrst(nrst), .start(start_v[0]), .mode(mode_v[0]), .data_in(din_v[0]),
    .addr(addr_v[0]), .wr_en(wr_v[0]), .data_out(dout_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass_cnt(pc_v[0]));

  mem_sweep_ctrl #(.DW(32), .AW(16), .BASE('h100), .STRIDE(8), .NWORDS(4), .NPASS(3), .CW(4)) u1 (
    .clk(clk), .nrst(nrst), .start(start_v[1]), .mode(mode_v[1]), .data_in(din_v[1]),
    .addr(addr_v[1]), .wr_en(wr_v[1]), .data_out(dout_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass_cnt(pc_v[1]));

  mem_sweep_ctrl #(.DW(32), .AW(16), .BASE('h40), .STRIDE(4), .NWORDS(1), .NPASS(3), .CW(4)) u2 (
    .clk(clk), .nrst(nrst), .start(start_v[2]), .mode(mode_v[2]), .data_in(din_v[2]),
    .addr(addr_v[2]), .wr_en(wr_v[2]), .data_out(dout_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .pass_cnt(pc_v[2]));

  // Asynchronous-read memories; an unmapped address returns a marker value
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      int off;
      off = int'(addr_v[k]) - BASE_A[k];
      din_v[k] = 32'hDEAD_BEEF;
      if (off >= 0 && (off % STRIDE_A[k]) == 0 && (off / STRIDE_A[k]) < NW_A[k])
        din_v[k] = mem[k][off / STRIDE_A[k]];
    end
  end

  function automatic logic [31:0] f(input logic [1:0] m, input logic [31:0] d);
    case (m)
      2'd0:    return d;
      2'd1:    return (d << 1) | (d >> 31);
      2'd2:    return ~d;
      default: return d + 32'd1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commit any write strobed this cycle, then advance to 1 time unit after the next rising edge
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      if (wr_v[k] === 1'b1) begin
        int off;
        off = int'(addr_v[k]) - BASE_A[k];
        if (off >= 0 && (off % STRIDE_A[k]) == 0 && (off / STRIDE_A[k]) < NW_A[k])
          mem[k][off / STRIDE_A[k]] = dout_v[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input int k, input string tag);
    chk($sformatf("%s d%0d wr_en", tag, k), 64'(wr_v[k]), 64'd0);
    chk($sformatf("%s d%0d busy", tag, k), 64'(busy_v[k]), 64'd0);
    chk($sformatf("%s d%0d done", tag, k), 64'(done_v[k]), 64'd0);
    chk($sformatf("%s d%0d addr", tag, k), 64'(addr_v[k]), 64'(BASE_A[k]));
    chk($sformatf("%s d%0d data_out", tag, k), 64'(dout_v[k]), 64'd0);
    chk($sformatf("%s d%0d pass_cnt", tag, k), 64'(pc_v[k]), 64'd0);
  endtask

  // Full run: cycle j after the start edge touches word ((j-1)/2)%NW; even cycles are the write
  task automatic run(input int k, input logic [1:0] m, input bit perturb);
    logic [31:0] model [4];
    int nw, np, total;
    nw = NW_A[k];
    np = NP_A[k];
    total = 2 * nw * np;
    for (int w = 0; w < 4; w++) model[w] = mem[k][w];
    mode_v[k]  = m;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    for (int j = 1; j <= total; j++) begin
      int w, p;
      w = ((j - 1) / 2) % nw;
      p = (j - 1) / (2 * nw);
      chk($sformatf("d%0d c%0d addr", k, j), 64'(addr_v[k]), 64'(BASE_A[k] + STRIDE_A[k] * w));
      chk($sformatf("d%0d c%0d wr_en", k, j), 64'(wr_v[k]), 64'((j % 2) == 0));
      chk($sformatf("d%0d c%0d busy", k, j), 64'(busy_v[k]), 64'd1);
      chk($sformatf("d%0d c%0d done", k, j), 64'(done_v[k]), 64'd0);
      chk($sformatf("d%0d c%0d pass_cnt", k, j), 64'(pc_v[k]), 64'(p));
      if ((j % 2) == 0) begin
        model[w] = f(m, model[w]);
        chk($sformatf("d%0d c%0d data_out", k, j), 64'(dout_v[k]), 64'(model[w]));
      end
      if (perturb && j == 3) begin
        start_v[k] = 1'b1;
        mode_v[k]  = 2'd2;
      end
      if (perturb && j == 4) start_v[k] = 1'b0;
      tick();
    end
    chk($sformatf("d%0d end done", k), 64'(done_v[k]), 64'd1);
    chk($sformatf("d%0d end busy", k), 64'(busy_v[k]), 64'd0);
    chk($sformatf("d%0d end wr_en", k), 64'(wr_v[k]), 64'd0);
    chk($sformatf("d%0d end addr", k), 64'(addr_v[k]), 64'(BASE_A[k]));
    chk($sformatf("d%0d end pass_cnt", k), 64'(pc_v[k]), 64'(np));
    chk($sformatf("d%0d end data_out", k), 64'(dout_v[k]), 64'(model[nw - 1]));
    for (int w = 0; w < nw; w++)
      chk($sformatf("d%0d mem[%0d]", k, w), 64'(mem[k][w]), 64'(model[w]));
    tick();
    chk($sformatf("d%0d done hold", k), 64'(done_v[k]), 64'd1);
    chk($sformatf("d%0d pass_cnt hold", k), 64'(pc_v[k]), 64'(np));
    mode_v[k] = 2'd0;
  endtask

  initial begin
    logic [31:0] snap [4];
    nrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      mode_v[k]  = 2'd0;
      for (int w = 0; w < 4; w++) mem[k][w] = $urandom;
    end
    #1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) chk_reset_state(k, "reset");
    nrst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) chk_reset_state(k, "idle");

    // Copy mode leaves memory untouched
    run(0, 2'd0, 1'b0);

    // Rotate across three passes at a non-zero base and wide stride
    mem[1][0] = 32'h8000_0001;
    run(1, 2'd1, 1'b0);
    chk("rotate word0 final", 64'(mem[1][0]), 64'h0000_000C);

    // Single-word increment wraps from all-ones, then invert
    mem[2][0] = 32'hFFFF_FFFF;
    run(2, 2'd3, 1'b0);
    chk("inc wrap final", 64'(mem[2][0]), 64'h0000_0002);
    mem[2][0] = 32'h0F0F_0F0F;
    run(2, 2'd2, 1'b0);
    chk("invert final", 64'(mem[2][0]), 64'hF0F0_F0F0);

    // start/mode changes while busy must be ignored
    for (int w = 0; w < 4; w++) mem[0][w] = $urandom;
    run(0, 2'd0, 1'b1);

    // Restart from DONE
    run(1, 2'd2, 1'b0);

    // Asynchronous reset during a WRITE cycle
    mode_v[0]  = 2'd2;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-reset wr_en", 64'(wr_v[0]), 64'd1);
    nrst = 1'b0;
    #1;
    chk_reset_state(0, "async");
    for (int w = 0; w < 4; w++) snap[w] = mem[0][w];
    tick();
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-reset wr_en %0d", i), 64'(wr_v[0]), 64'd0);
      chk($sformatf("post-reset busy %0d", i), 64'(busy_v[0]), 64'd0);
    end
    for (int w = 0; w < 4; w++)
      chk($sformatf("post-reset mem[%0d]", w), 64'(mem[0][w]), 64'(snap[w]));
    run(0, 2'd2, 1'b0);

    // Randomised runs
    for (int i = 0; i < 8; i++) begin
      int k;
      logic [1:0] m;
      k = int'($urandom_range(0, 2));
      m = 2'($urandom_range(0, 3));
      for (int w = 0; w < 4; w++) mem[k][w] = $urandom;
      run(k, m, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
